// File: rtl/board_window_sampler_pkg.sv
// Shared types and helpers for the board window sampler and its consumers.
package board_window_sampler_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      HOLD
   } sampler_state_e;

   // Cells outside the playfield walls and below the floor read as occupied.
   localparam logic WALL_FILL = 1'b1;

   localparam int unsigned DEF_WIN = 6;

   // Flat bit index of window cell (lx, ly); lx is the column, ly the row.
   function automatic int unsigned win_idx(input int unsigned lx,
                                           input int unsigned ly,
                                           input int unsigned win = DEF_WIN);
      return lx * win + ly;
   endfunction

endpackage

// File: rtl/board_window_sampler_if.sv
// Request and window handshake channels of the board window sampler.
interface board_window_sampler_if #(
   parameter int XW  = 6,
   parameter int YW  = 7,
   parameter int WIN = 6
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic signed [XW-1:0]  req_x;
   logic signed [YW-1:0]  req_y;

   logic                  win_valid;
   logic                  win_ready;
   logic [WIN*WIN-1:0]    win_data;

   // Requester / window consumer side.
   modport master (
      output req_valid, req_x, req_y, win_ready,
      input  req_ready, win_valid, win_data
   );

   // Sampler side.
   modport slave (
      input  req_valid, req_x, req_y, win_ready,
      output req_ready, win_valid, win_data
   );

endinterface

// File: rtl/board_window_sampler_slicer.sv
// Turns one returned board column into WIN window cells, applying the
// wall, spawn-zone and floor fills around the visible playfield.
module board_column_slicer
   import board_window_sampler_pkg::*;
#(
   parameter int unsigned WIN          = 6,
   parameter int unsigned BOARD_HEIGHT = 20,
   parameter int          ORIGIN_OFF   = 1,
   parameter bit          TOP_FILL     = 1'b0,
   parameter int          YW           = $clog2(BOARD_HEIGHT) + 2
) (
   input  logic [BOARD_HEIGHT-1:0] col_data,
   input  logic                    in_bounds,
   input  logic signed [YW-1:0]    y_lat,
   output logic [WIN-1:0]          col_bits
);

   localparam int YAW = $clog2(BOARD_HEIGHT);

   // Per-row world y, computed one bit wider than y so extremes never wrap.
   always_comb begin
      logic signed [YW:0] wy;
      col_bits = '0;
      wy       = '0;
      for (int unsigned ly = 0; ly < WIN; ly++) begin
         wy = signed'({y_lat[YW-1], y_lat}) + signed'((YW+1)'(ly))
              - signed'((YW+1)'(ORIGIN_OFF));
         if (!in_bounds) begin
            col_bits[ly] = WALL_FILL;
         end else if (wy < 0) begin
            col_bits[ly] = TOP_FILL;
         end else if (wy >= signed'((YW+1)'(BOARD_HEIGHT))) begin
            col_bits[ly] = WALL_FILL;
         end else begin
            col_bits[ly] = col_data[wy[YAW-1:0]];
         end
      end
   end

endmodule

// File: rtl/board_window_sampler.sv
// Sequential WIN x WIN window sampler: reads one board column per cycle
// from a column-addressed RAM and assembles the neighbourhood of a piece.
module board_window_sampler
   import board_window_sampler_pkg::*;
#(
   parameter int unsigned BOARD_WIDTH  = 10,
   parameter int unsigned BOARD_HEIGHT = 20,
   parameter int unsigned WIN          = 6,
   parameter int          ORIGIN_OFF   = 1,
   parameter int unsigned READ_LAT     = 1,
   parameter bit          TOP_FILL     = 1'b0,
   parameter int          XW           = $clog2(BOARD_WIDTH) + 2,
   parameter int          YW           = $clog2(BOARD_HEIGHT) + 2
) (
   input  logic                           clk,
   input  logic                           reset_n,
   board_window_sampler_if.slave          bus,
   output logic                           col_rd_en,
   output logic [$clog2(BOARD_WIDTH)-1:0] col_rd_addr,
   input  logic [BOARD_HEIGHT-1:0]        col_rd_data
);

   localparam int AW  = $clog2(BOARD_WIDTH);
   localparam int LXW = (WIN > 1) ? $clog2(WIN) : 1;

   typedef struct packed {
      logic           v;
      logic [LXW-1:0] lx;
      logic           ib;
   } tag_t;

   sampler_state_e       state, state_nx;
   logic signed [XW-1:0] x_lat;
   logic signed [YW-1:0] y_lat;
   logic [LXW-1:0]       col_cnt;
   logic                 issuing;
   logic                 in_bounds;
   logic [AW-1:0]        wx_addr;
   tag_t                 tag_q [READ_LAT];
   tag_t                 tag_out;
   logic [WIN-1:0]       col_bits;
   logic [WIN*WIN-1:0]   col_field;
   logic [WIN*WIN-1:0]   col_mask;
   logic [WIN*WIN-1:0]   win_q;

   assign tag_out      = tag_q[READ_LAT-1];
   assign bus.win_data = win_q;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nx      = state;
      bus.req_ready = 1'b0;
      bus.win_valid = 1'b0;
      issuing       = 1'b0;
      unique case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nx = ISSUE;
         end
         ISSUE: begin
            issuing = 1'b1;
            if (col_cnt == LXW'(WIN - 1)) state_nx = DRAIN;
         end
         DRAIN: begin
            if (tag_out.v && tag_out.lx == LXW'(WIN - 1)) state_nx = HOLD;
         end
         HOLD: begin
            bus.win_valid = 1'b1;
            if (bus.win_ready) state_nx = IDLE;
         end
      endcase
   end

   // World column of the column being issued, one bit wider than x.
   always_comb begin
      logic signed [XW:0] wx;
      wx = signed'({x_lat[XW-1], x_lat}) + signed'((XW+1)'(col_cnt))
           - signed'((XW+1)'(ORIGIN_OFF));
      in_bounds = (wx >= 0) && (wx < signed'((XW+1)'(BOARD_WIDTH)));
      wx_addr   = wx[AW-1:0];
   end

   // RAM strobe only for on-board columns; off-board columns become walls.
   always_comb begin
      col_rd_en   = issuing && in_bounds;
      col_rd_addr = (issuing && in_bounds) ? wx_addr : '0;
   end

   // Request latch and column counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_lat   <= '0;
         y_lat   <= '0;
         col_cnt <= '0;
      end else if (state == IDLE && bus.req_valid) begin
         x_lat   <= bus.req_x;
         y_lat   <= bus.req_y;
         col_cnt <= '0;
      end else if (state == ISSUE) begin
         col_cnt <= col_cnt + 1'b1;
      end
   end

   // Tag pipeline matching the RAM latency; every issued column, in bounds
   // or not, travels through it so all columns land with uniform timing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < READ_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{v: issuing, lx: col_cnt, ib: in_bounds};
         for (int unsigned i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   board_column_slicer #(
      .WIN          (WIN),
      .BOARD_HEIGHT (BOARD_HEIGHT),
      .ORIGIN_OFF   (ORIGIN_OFF),
      .TOP_FILL     (TOP_FILL),
      .YW           (YW)
   ) u_slicer (
      .col_data  (col_rd_data),
      .in_bounds (tag_out.ib),
      .y_lat     (y_lat),
      .col_bits  (col_bits)
   );

   // Position the sliced column at its lx slot in the window.
   always_comb begin
      col_field = (WIN*WIN)'(col_bits) << win_idx(32'(tag_out.lx), 0, WIN);
      col_mask  = (WIN*WIN)'({WIN{1'b1}}) << win_idx(32'(tag_out.lx), 0, WIN);
   end

   // Window register: one column written as each tag exits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      win_q <= '0;
      else if (tag_out.v) win_q <= (win_q & ~col_mask) | (col_field & col_mask);
   end

endmodule

// File: tb/tb_board_window_sampler.sv
// Directed bench for board_window_sampler: three instances (defaults,
// TOP_FILL=1, READ_LAT=3) sharing one board image and one reset.
module tb_board_window_sampler;
   import board_window_sampler_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   board_window_sampler_if #(.XW(6), .YW(7), .WIN(6)) bus0 ();
   board_window_sampler_if #(.XW(6), .YW(7), .WIN(6)) bus1 ();
   board_window_sampler_if #(.XW(6), .YW(7), .WIN(6)) bus2 ();

   logic              rv [3];
   logic signed [5:0] rx [3];
   logic signed [6:0] ry [3];
   logic              wr [3];
   logic              rr [3];
   logic              wv [3];
   logic [35:0]       wd [3];
   logic              en [3];
   logic [3:0]        addr [3];
   logic [19:0]       rdat0, rdat1, rdat2a, rdat2b, rdat2c;

   assign bus0.req_valid = rv[0]; assign bus0.req_x = rx[0]; assign bus0.req_y = ry[0]; assign bus0.win_ready = wr[0];
   assign bus1.req_valid = rv[1]; assign bus1.req_x = rx[1]; assign bus1.req_y = ry[1]; assign bus1.win_ready = wr[1];
   assign bus2.req_valid = rv[2]; assign bus2.req_x = rx[2]; assign bus2.req_y = ry[2]; assign bus2.win_ready = wr[2];
   assign rr[0] = bus0.req_ready; assign wv[0] = bus0.win_valid; assign wd[0] = bus0.win_data;
   assign rr[1] = bus1.req_ready; assign wv[1] = bus1.win_valid; assign wd[1] = bus1.win_data;
   assign rr[2] = bus2.req_ready; assign wv[2] = bus2.win_valid; assign wd[2] = bus2.win_data;

   board_window_sampler u_dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0),
      .col_rd_en(en[0]), .col_rd_addr(addr[0]), .col_rd_data(rdat0));

   board_window_sampler #(.TOP_FILL(1'b1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1),
      .col_rd_en(en[1]), .col_rd_addr(addr[1]), .col_rd_data(rdat1));

   board_window_sampler #(.READ_LAT(3)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2),
      .col_rd_en(en[2]), .col_rd_addr(addr[2]), .col_rd_data(rdat2c));

   // Board RAM model; unstrobed or out-of-range reads return junk.
   logic [19:0] board [10];

   function automatic logic [19:0] rd(input logic e, input logic [3:0] a);
      if (e && a < 4'd10) return board[a];
      return 20'hAAAAA;
   endfunction

   always @(posedge clk) begin
      rdat0  <= rd(en[0], addr[0]);
      rdat1  <= rd(en[1], addr[1]);
      rdat2a <= rd(en[2], addr[2]);
      rdat2b <= rdat2a;
      rdat2c <= rdat2b;
   end

   // Read log: instance*100 + address.
   int alog[$];
   always @(posedge clk) begin
      if (en[0]) alog.push_back(int'(addr[0]));
      if (en[1]) alog.push_back(100 + int'(addr[1]));
      if (en[2]) alog.push_back(200 + int'(addr[2]));
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          k;     // instance
      int          x;
      int          y;
      int          brd;   // 0 empty, 1 cell (4,10), 2 column 3 = rows 0 and 2
      int          hold;  // cycles win_ready held low
      logic [35:0] win;
      int          lat;   // edges from request handshake to win_valid
      int          nrd;   // RAM reads issued
      int          a0;    // first read address
   } vec_t;

   vec_t vecs [10];

   task automatic load_board(input int brd);
      for (int c = 0; c < 10; c++) board[c] = '0;
      if (brd == 1) board[4][10] = 1'b1;
      if (brd == 2) board[3] = 20'h00005;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int          n;
      bit          got, bad_rr, bad_hold, seq_ok;
      int          nrd;
      logic [35:0] snap;
      load_board(v.brd);
      alog.delete();
      @(negedge clk);
      chk($sformatf("v%0d req_ready_idle", id), 64'(rr[v.k]), 64'(1));
      rv[v.k] = 1'b1;
      rx[v.k] = v.x[5:0];
      ry[v.k] = v.y[6:0];
      @(posedge clk);
      #1 rv[v.k] = 1'b0;
      n = 0; got = 0; bad_rr = 0;
      while (!got && n < 40) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (wv[v.k]) got = 1;
         if (rr[v.k]) bad_rr = 1;
      end
      chk($sformatf("v%0d win_latency", id), 64'(n), 64'(v.lat));
      chk($sformatf("v%0d win_data", id), 64'(wd[v.k]), 64'(v.win));
      snap = wd[v.k];
      bad_hold = 0;
      wr[v.k] = 1'b0;
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         if (wd[v.k] !== snap || !wv[v.k] || rr[v.k]) bad_hold = 1;
      end
      chk($sformatf("v%0d hold_stable", id), 64'(bad_hold), 64'(0));
      chk($sformatf("v%0d req_ready_busy", id), 64'(bad_rr), 64'(0));
      wr[v.k] = 1'b1;
      @(posedge clk);
      #1 wr[v.k] = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d back_to_idle", id), 64'({wv[v.k], rr[v.k]}), 64'(2'b01));
      nrd = 0; seq_ok = 1;
      foreach (alog[i]) begin
         if (alog[i] / 100 == v.k) begin
            if (alog[i] % 100 != v.a0 + nrd) seq_ok = 0;
            nrd++;
         end
      end
      chk($sformatf("v%0d read_count", id), 64'(nrd), 64'(v.nrd));
      chk($sformatf("v%0d read_addr_seq", id), 64'(seq_ok), 64'(1));
   endtask

   vec_t post_rst;

   initial begin
      // k   x    y    brd hold win            lat nrd a0
      vecs[0] = '{0,   4,  10, 1, 0,  36'h000000080, 7, 6, 3}; // centred
      vecs[1] = '{0,   0,   5, 0, 0,  36'h00000003F, 7, 5, 0}; // left wall
      vecs[2] = '{0,   3,  18, 0, 2,  36'hE38E38E38, 7, 6, 2}; // floor
      vecs[3] = '{0,   4,  -2, 2, 0,  36'h000000028, 7, 6, 3}; // spawn, fill 0
      vecs[4] = '{1,   4,  -2, 2, 0,  36'h1C71C71EF, 7, 6, 3}; // spawn, fill 1
      vecs[5] = '{2,   4,  10, 1, 10, 36'h000000080, 9, 6, 3}; // READ_LAT=3
      vecs[6] = '{0,   9,   5, 0, 0,  36'hFFFFFF000, 7, 2, 8}; // right wall
      vecs[7] = '{0, -32,   3, 0, 0,  36'hFFFFFFFFF, 7, 0, 0}; // x minimum
      vecs[8] = '{2,   3,  18, 0, 1,  36'hE38E38E38, 9, 6, 2}; // floor, lat 3
      vecs[9] = '{0,   4, -64, 0, 0,  36'h000000000, 7, 6, 3}; // y minimum
      post_rst = '{0,  4,  10, 0, 0,  36'h000000000, 7, 6, 3};

      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rv[k] = 1'b0; wr[k] = 1'b0; rx[k] = '0; ry[k] = '0;
      end
      load_board(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst req_ready", 64'(rr[0]), 64'(1));
      chk("rst win_valid", 64'(wv[0]), 64'(0));
      chk("rst col_rd_en", 64'(en[0]), 64'(0));
      chk("rst col_rd_addr", 64'(addr[0]), 64'(0));
      chk("rst win_data", 64'(wd[0]), 64'(0));
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Abort during the third ISSUE cycle (lx=2, wx=5).
      load_board(1);
      @(negedge clk);
      rv[0] = 1'b1; rx[0] = 6'sd4; ry[0] = 7'sd10;
      @(posedge clk);
      #1 rv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("scan col_rd_en", 64'(en[0]), 64'(1));
      chk("scan col_rd_addr", 64'(addr[0]), 64'(5));
      #1 reset_n = 1'b0;
      #1;
      chk("abort outputs", 64'({rr[0], wv[0], en[0], addr[0]}), 64'(7'b1000000));
      chk("abort win_data", 64'(wd[0]), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("after abort win_data", 64'(wd[0]), 64'(0));
      chk("after abort win_valid", 64'(wv[0]), 64'(0));
      run_vec(post_rst, 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/board_window_sampler.md
Name: board_window_sampler

Overview:
- Sequential, parametrised window sampler for the GAME_clk domain.
- Reads a WIN x WIN neighbourhood of the playfield around a requested piece position.
- Reads the board one column per cycle from a column-addressed board RAM, so the full screen does not need to be flattened combinationally.
- Accepts requests and delivers windows over valid/ready handshakes; feeds collision and rotation checkers.

Parameters:
- BOARD_WIDTH, 10, playfield columns.
- BOARD_HEIGHT, 20, playfield rows (bits per RAM word).
- WIN, 6, window edge length in cells.
- ORIGIN_OFF, 1, window top-left = (req_x-ORIGIN_OFF, req_y-ORIGIN_OFF).
- READ_LAT, 1, board RAM read latency in cycles (1..4).
- TOP_FILL, 0, fill bit for cells with world y < 0 (spawn zone above screen).
- XW, $clog2(BOARD_WIDTH)+2, signed x width (derived).
- YW, $clog2(BOARD_HEIGHT)+2, signed y width (derived).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_x  in  XW  signed piece x (negative allowed).
- req_y  in  YW  signed piece y (negative allowed).
- col_rd_en  out  1  board RAM read strobe.
- col_rd_addr  out  $clog2(BOARD_WIDTH)  column address.
- col_rd_data  in  BOARD_HEIGHT  column word; bit n = row n; valid READ_LAT cycles after its strobe.
- win_valid  out  1  window ready for the consumer.
- win_ready  in  1  consumer accepts the window.
- win_data  out  WIN*WIN  bit (lx*WIN+ly) = cell (lx,ly); lx is the column, ly is the row, y increases downward.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=1, win_valid=0, col_rd_en=0, col_rd_addr=0, win_data=0.
- Reset asserted mid-scan aborts the scan immediately. Late RAM returns are ignored (the tag pipeline is cleared).
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE: req_ready=1. Handshake on edge E0 latches req_x/req_y and clears the column counter; go to ISSUE.
- ISSUE: lasts exactly WIN cycles. Column lx=0..WIN-1 is issued one per cycle. World column wx = x_lat+lx-ORIGIN_OFF, computed signed at XW+1 bits.
  - If 0 <= wx < BOARD_WIDTH: col_rd_en=1, col_rd_addr=wx.
  - Otherwise: col_rd_en=0 and the column is filled with all 1s (wall).
  - After the last column, go to DRAIN.
- Tag pipeline: a READ_LAT-deep shift register carries {valid, lx, in_bounds} alongside each issue. On tag exit, the column is written into win_data.
- Per-row fill for an in-bounds column: wy = y_lat+ly-ORIGIN_OFF.
  - wy < 0 -> TOP_FILL.
  - wy >= BOARD_HEIGHT -> 1 (floor).
  - Otherwise -> col_rd_data[wy].
- DRAIN: waits for the last tag to exit, then goes to HOLD. win_valid rises on edge E0+WIN+READ_LAT exactly.
- HOLD: win_valid=1. win_data is stable until the win_valid&&win_ready handshake, then IDLE.
- Back-to-back: req_ready=0 outside IDLE, so a new request is accepted no earlier than the cycle after the window handshake.
- Throughput: one window per WIN+READ_LAT+2 cycles.
- Simultaneous events: req_valid arriving during HOLD is held off by the requester (no drop, no overwrite).
- Arithmetic: all world-coordinate math is signed and wide enough that req_x = -(2^(XW-1)) cannot wrap into range.
- Never issue col_rd_addr >= BOARD_WIDTH.

Decomposition:
- game_state_pkg gains:
  - sampler_state_e (IDLE/ISSUE/DRAIN/HOLD).
  - WALL_FILL=1'b1 constant.
  - function win_idx(lx,ly) returning lx*WIN+ly, shared with the collision checker.
- Sub-module board_column_slicer: combinational wy/fill logic for one returned column, parametrised by WIN, BOARD_HEIGHT, ORIGIN_OFF, TOP_FILL. It is instanced once at the tag-pipeline output.

Test Plan:
- Centred request: board with only cell (4,10) set; req (4,10), defaults -> win_valid at E0+7; win_data has bit win_idx(1,1)=1 and all other bits 0; col_rd_addr sequence 3,4,5,6,7,8.
- Left edge: empty board, req (0,5) -> column lx=0 all 1s with no read issued for it; 5 reads at addresses 0..4; the rest of the window is 0.
- Floor: empty board, req (3,18) -> rows ly=3..5 (wy 20..22) are 1 in every column; other rows are 0.
- Spawn above top: req (4,-2), TOP_FILL=0 and then TOP_FILL=1 -> rows ly=0..2 are 0 and 1 respectively; rows from wy=0 come from RAM.
- Backpressure and latency: READ_LAT=3 with win_ready held low 10 cycles -> win_valid rises at E0+9; win_data stable; req_ready=0 throughout; handshake then returns to IDLE.
- Reset mid-scan: assert reset_n=0 during the 3rd ISSUE cycle -> all outputs at reset values asynchronously; next request's window contains no stale columns.
